// File: rtl/ss_pkg.sv
// Shared definitions for the skew feeder and the systolic array it drives:
// state encoding, default geometry and the matrix-size encoding.
package ss_pkg;

  localparam int DATA_W = 16;
  localparam int MAX_N  = 4;

  localparam logic SIZE_2X2 = 1'b0;
  localparam logic SIZE_4X4 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_LOAD_X = 2'd2,
    ST_FEED   = 2'd3
  } ss_state_e;

  // Dimension selected by the size code; the large size is the array size.
  function automatic int size_to_n(input logic size, input int max_n);
    return (size == SIZE_4X4) ? max_n : 2;
  endfunction

endpackage

// File: rtl/ss_mat_buf.sv
// MAX_N x MAX_N element store: one row-major write port, MAX_N combinational
// read ports (one per feed lane).
module ss_mat_buf
  import ss_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MAX_N  = 4,
  localparam int IDX_W = $clog2(MAX_N * MAX_N),
  localparam int RC_W  = $clog2(MAX_N)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic                           wr_size,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic [MAX_N-1:0][RC_W-1:0]     rd_row,
  input  logic [MAX_N-1:0][RC_W-1:0]     rd_col,
  output logic [MAX_N-1:0][DATA_W-1:0]   rd_data
);

  logic [DATA_W-1:0] mem [MAX_N][MAX_N];
  logic [RC_W-1:0]   wr_row;
  logic [RC_W-1:0]   wr_col;

  // Row-major index splits on the active dimension (2 or MAX_N, both powers of two).
  always_comb begin
    if (wr_size == SIZE_4X4) begin
      wr_row = RC_W'(wr_idx >> RC_W);
      wr_col = wr_idx[RC_W-1:0];
    end else begin
      wr_row = RC_W'(wr_idx >> 1);
      wr_col = RC_W'(wr_idx[0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MAX_N; r++) begin
        for (int c = 0; c < MAX_N; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_N; i++) begin
      rd_data[i] = mem[rd_row[i]][rd_col[i]];
    end
  end

endmodule

// File: rtl/ss_skew_feeder.sv
// Loads W then X as a row-major element stream, then emits 2N-1 skewed
// wavefronts (rows of W on the west edge, columns of X on the north edge).
module ss_skew_feeder #(
  parameter int DATA_W = ss_pkg::DATA_W,
  parameter int MAX_N  = ss_pkg::MAX_N
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       matrix,
  input  logic                    matrix_size,
  output logic                    in_ready,
  output logic                    feed_valid,
  output logic                    feed_first,
  output logic                    feed_last,
  output logic                    feed_size,
  output logic [MAX_N*DATA_W-1:0] west_data,
  output logic [MAX_N*DATA_W-1:0] north_data,
  output ss_pkg::ss_state_e       state_dbg
);
  import ss_pkg::*;

  // Handshake: an element transfers on a rising edge where in_valid && in_ready;
  // the source may insert idle cycles freely, and in_ready drops for the whole feed.

  localparam int IDX_W  = $clog2(MAX_N * MAX_N);
  localparam int STEP_W = $clog2(2 * MAX_N - 1);
  localparam int RC_W   = $clog2(MAX_N);

  ss_state_e          state, state_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [STEP_W-1:0]  step, step_d;
  logic               size_q, size_d;
  logic               accept;
  logic               w_we, x_we, wr_size;
  int                 n_cur, n_d;
  logic               feeding;

  logic [MAX_N-1:0][RC_W-1:0]   w_rd_row, w_rd_col, x_rd_row, x_rd_col;
  logic [MAX_N-1:0][DATA_W-1:0] w_rd, x_rd;
  logic [MAX_N-1:0]             lane_hit;
  logic [MAX_N*DATA_W-1:0]      west_d, north_d;

  assign accept    = in_valid && in_ready;
  assign n_cur     = size_to_n(size_q, MAX_N);
  assign state_dbg = state;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    step_d  = step;
    size_d  = size_q;
    w_we    = 1'b0;
    x_we    = 1'b0;
    wr_size = size_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          size_d  = matrix_size;
          wr_size = matrix_size;
          w_we    = 1'b1;
          idx_d   = IDX_W'(1);
          state_d = ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (accept) begin
          w_we = 1'b1;
          if (int'(idx) == n_cur * n_cur - 1) begin
            idx_d   = '0;
            state_d = ST_LOAD_X;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      ST_LOAD_X: begin
        if (accept) begin
          x_we = 1'b1;
          if (int'(idx) == n_cur * n_cur - 1) begin
            idx_d   = '0;
            step_d  = '0;
            state_d = ST_FEED;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      ST_FEED: begin
        if (int'(step) == 2 * n_cur - 2) begin
          step_d  = '0;
          state_d = ST_IDLE;
        end else begin
          step_d = step + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next step so the registered wavefront lines up
  // with the state; step 0 only reads [0][0], which is stored well before the last X beat.
  assign n_d     = size_to_n(size_d, MAX_N);
  assign feeding = (state_d == ST_FEED);

  always_comb begin
    lane_hit = '0;
    w_rd_row = '0;
    w_rd_col = '0;
    x_rd_row = '0;
    x_rd_col = '0;
    west_d   = '0;
    north_d  = '0;
    for (int i = 0; i < MAX_N; i++) begin
      lane_hit[i] = feeding && (i < n_d) && (int'(step_d) >= i) &&
                    (int'(step_d) - i < n_d);
      w_rd_row[i] = RC_W'(i);
      x_rd_col[i] = RC_W'(i);
      if (lane_hit[i]) begin
        w_rd_col[i] = RC_W'(int'(step_d) - i);
        x_rd_row[i] = RC_W'(int'(step_d) - i);
        west_d[DATA_W*i +: DATA_W]  = w_rd[i];
        north_d[DATA_W*i +: DATA_W] = x_rd[i];
      end
    end
  end

  ss_mat_buf #(.DATA_W(DATA_W), .MAX_N(MAX_N)) u_w_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_we),
    .wr_size (wr_size),
    .wr_idx  (idx),
    .wr_data (matrix),
    .rd_row  (w_rd_row),
    .rd_col  (w_rd_col),
    .rd_data (w_rd)
  );

  ss_mat_buf #(.DATA_W(DATA_W), .MAX_N(MAX_N)) u_x_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (x_we),
    .wr_size (wr_size),
    .wr_idx  (idx),
    .wr_data (matrix),
    .rd_row  (x_rd_row),
    .rd_col  (x_rd_col),
    .rd_data (x_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      step       <= '0;
      size_q     <= SIZE_2X2;
      in_ready   <= 1'b1;
      feed_valid <= 1'b0;
      feed_first <= 1'b0;
      feed_last  <= 1'b0;
      feed_size  <= 1'b0;
      west_data  <= '0;
      north_data <= '0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      step       <= step_d;
      size_q     <= size_d;
      in_ready   <= !feeding;
      feed_valid <= feeding;
      feed_first <= feeding && (step_d == '0);
      feed_last  <= feeding && (int'(step_d) == 2 * n_d - 2);
      feed_size  <= feeding ? size_d : 1'b0;
      west_data  <= west_d;
      north_data <= north_d;
    end
  end

endmodule

// File: tb/tb_ss_skew_feeder.sv
// Directed bench for ss_skew_feeder: a wavefront model built from W/X lists,
// a per-cycle compare process, and literal checks of known wavefronts.
module tb_ss_skew_feeder;
  localparam int DATA_W = 16;
  localparam int MAX_N  = 4;
  localparam int LW     = MAX_N * DATA_W;
  localparam int EXP_W  = 2 * LW + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] matrix = '0;
  logic              matrix_size = 1'b0;
  logic              in_ready, feed_valid, feed_first, feed_last, feed_size;
  logic [LW-1:0]     west_data, north_data;
  ss_pkg::ss_state_e state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  logic [EXP_W-1:0] exp_q[$];
  logic [LW-1:0]    obs_west[$];
  logic [LW-1:0]    obs_north[$];
  logic             obs_last[$];
  logic             obs_size[$];

  logic [DATA_W-1:0] w_a [16];
  logic [DATA_W-1:0] x_a [16];
  logic [DATA_W-1:0] w_b [16];
  logic [DATA_W-1:0] x_b [16];

  ss_skew_feeder #(.DATA_W(DATA_W), .MAX_N(MAX_N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .matrix      (matrix),
    .matrix_size (matrix_size),
    .in_ready    (in_ready),
    .feed_valid  (feed_valid),
    .feed_first  (feed_first),
    .feed_last   (feed_last),
    .feed_size   (feed_size),
    .west_data   (west_data),
    .north_data  (north_data),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_outputs", {feed_valid, feed_first, feed_last, feed_size, west_data, north_data}, 0);
    check("reset_state", state_dbg, ss_pkg::ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);
    check("post_reset_feed_valid", feed_valid, 0);
    mon_en = 1'b1;
  endtask

  // Model: wavefront t carries W[i][t-i] on west lane i and X[t-j][j] on north lane j.
  task automatic model_push(input logic sz, input logic [DATA_W-1:0] w [16],
                            input logic [DATA_W-1:0] x [16]);
    int n;
    logic [LW-1:0] we, no;
    n = sz ? 4 : 2;
    for (int t = 0; t <= 2 * n - 2; t++) begin
      we = '0;
      no = '0;
      for (int i = 0; i < MAX_N; i++) begin
        if (i < n && t - i >= 0 && t - i < n) begin
          we[DATA_W*i +: DATA_W] = w[i * n + (t - i)];
          no[DATA_W*i +: DATA_W] = x[(t - i) * n + i];
        end
      end
      exp_q.push_back({(t == 0), (t == 2 * n - 2), sz, we, no});
    end
  endtask

  // driver tasks
  task automatic send(input logic [DATA_W-1:0] v, input logic sz);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid    = 1'b1;
    matrix      = v;
    matrix_size = sz;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    matrix      = 16'hDEAD;
    matrix_size = ~sz;
  endtask

  task automatic load_product(input logic sz, input logic [DATA_W-1:0] w [16],
                              input logic [DATA_W-1:0] x [16], input bit gap, input bit flip);
    int n;
    n = sz ? 4 : 2;
    model_push(sz, w, x);
    for (int k = 0; k < n * n; k++) begin
      send(w[k], (k == 0 || !flip) ? sz : ~sz);
      if (gap) @(negedge clk);
    end
    for (int k = 0; k < n * n; k++) begin
      send(x[k], flip ? ~sz : sz);
      if (gap && k != n * n - 1) @(negedge clk);
    end
    @(negedge clk);
    check("feed_starts_after_last_x", {feed_valid, feed_first}, 2'b11);
  endtask

  task automatic wait_feed_done();
    int c;
    c = 0;
    while (!feed_last && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("feed_last_seen", feed_last, 1);
    @(negedge clk);
    check("in_ready_after_last", in_ready, 1);
  endtask

  task automatic check_size2_tail(input string tag);
    int b;
    check({tag, "_beats"}, (obs_west.size() >= 3), 1);
    b = (obs_west.size() >= 3) ? obs_west.size() - 3 : 0;
    check({tag, "_t0_west"},  obs_west[b],    {16'd0, 16'd0, 16'd0, 16'd1});
    check({tag, "_t0_north"}, obs_north[b],   {16'd0, 16'd0, 16'd0, 16'd5});
    check({tag, "_t1_west"},  obs_west[b+1],  {16'd0, 16'd0, 16'd3, 16'd2});
    check({tag, "_t1_north"}, obs_north[b+1], {16'd0, 16'd0, 16'd6, 16'd7});
    check({tag, "_t2_west"},  obs_west[b+2],  {16'd0, 16'd0, 16'd4, 16'd0});
    check({tag, "_t2_north"}, obs_north[b+2], {16'd0, 16'd0, 16'd8, 16'd0});
    check({tag, "_last_flags"}, {obs_last[b], obs_last[b+1], obs_last[b+2]}, 3'b001);
    check({tag, "_size"}, obs_size[b+2], 0);
  endtask

  // scoreboard: compare every cycle against the model queue
  always @(negedge clk) begin
    if (mon_en) begin
      if (feed_valid) begin
        check("in_ready_low_in_feed", in_ready, 0);
        obs_west.push_back(west_data);
        obs_north.push_back(north_data);
        obs_last.push_back(feed_last);
        obs_size.push_back(feed_size);
        if (exp_q.size() == 0) check("unexpected_wavefront", feed_valid, 0);
        else check("wavefront", {feed_first, feed_last, feed_size, west_data, north_data},
                   exp_q.pop_front());
      end else begin
        check("idle_outputs", {feed_first, feed_last, 1'b0, west_data, north_data}, 0);
      end
    end
  end

  initial begin
    int c, b;
    for (int k = 0; k < 16; k++) begin
      w_a[k] = '0;
      x_a[k] = '0;
      w_b[k] = DATA_W'(k + 1);
      x_b[k] = (k % 5 == 0) ? 16'd1 : 16'd0;
    end
    for (int k = 0; k < 4; k++) begin
      w_a[k] = DATA_W'(k + 1);
      x_a[k] = DATA_W'(k + 5);
    end

    do_reset();

    // size 2, contiguous
    load_product(1'b0, w_a, x_a, 1'b0, 1'b0);
    wait_feed_done();
    check_size2_tail("s2_contig");

    // size 4, W = 1..16, X = identity
    load_product(1'b1, w_b, x_b, 1'b0, 1'b0);
    wait_feed_done();
    check("s4_beats", (obs_west.size() >= 7), 1);
    b = (obs_west.size() >= 7) ? obs_west.size() - 7 : 0;
    check("s4_t0_west",  obs_west[b],    {16'd0, 16'd0, 16'd0, 16'd1});
    check("s4_t0_north", obs_north[b],   {16'd0, 16'd0, 16'd0, 16'd1});
    check("s4_t6_west",  obs_west[b+6],  {16'd16, 16'd0, 16'd0, 16'd0});
    check("s4_t6_north", obs_north[b+6], {16'd1, 16'd0, 16'd0, 16'd0});
    check("s4_t6_last",  obs_last[b+6], 1);

    // size 2 with gaps and matrix_size flipped after the first beat
    load_product(1'b0, w_a, x_a, 1'b1, 1'b1);
    wait_feed_done();
    check_size2_tail("s2_gaps");

    // abandon a size-4 load after 10 elements
    for (int k = 0; k < 10; k++) send(DATA_W'(16'h0A00 + k), 1'b1);
    do_reset();
    c = 0;
    while (c < 20) begin
      @(negedge clk);
      c++;
    end
    check("no_feed_after_abort", obs_west.size() >= 3, 1);
    load_product(1'b0, w_a, x_a, 1'b0, 1'b0);
    wait_feed_done();
    check_size2_tail("s2_after_abort");

    // in_valid held with 0xFFFF during a feed, then back-to-back product
    for (int k = 0; k < 16; k++) w_b[k] = DATA_W'(16'h0100 + k * 3);
    load_product(1'b1, w_b, x_a, 1'b0, 1'b0);
    c = 0;
    while (!feed_last && c < 40) begin
      in_valid = 1'b1;
      matrix   = 16'hFFFF;
      @(negedge clk);
      c++;
    end
    in_valid = 1'b0;
    check("garbage_feed_last_seen", feed_last, 1);
    load_product(1'b0, w_a, x_a, 1'b0, 1'b0);
    wait_feed_done();
    check_size2_tail("s2_back_to_back");

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ss_skew_feeder.md
SS_SKEW_FEEDER -- requirements
Module: ss_skew_feeder

Interface
REQ-001 Parameter DATA_W, default 16, width of one matrix element.
REQ-002 Parameter MAX_N, default 4, largest supported matrix dimension and number of feed lanes.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  element on matrix is presented this cycle.
REQ-006 matrix  input  DATA_W  element stream: W row-major, then X row-major.
REQ-007 matrix_size  input  1  0 = 2x2, 1 = 4x4; meaningful on first beat of a load only.
REQ-008 in_ready  output  1  block accepts elements (IDLE, LOAD_W, LOAD_X).
REQ-009 feed_valid  output  1  west_data/north_data carry a systolic wavefront.
REQ-010 feed_first  output  1  first wavefront; array clears accumulators.
REQ-011 feed_last  output  1  final wavefront of the product.
REQ-012 feed_size  output  1  latched matrix_size of the product being fed.
REQ-013 west_data  output  MAX_N*DATA_W  lane i at bits [DATA_W*i +: DATA_W], row i of array.
REQ-014 north_data  output  MAX_N*DATA_W  lane j at bits [DATA_W*j +: DATA_W], column j of array.

Function
REQ-015 States IDLE, LOAD_W, LOAD_X, FEED; reset state IDLE.
REQ-016 An element is accepted when in_valid && in_ready; gaps of any length between accepted elements are legal.
REQ-017 IDLE: first accepted element latches N (2 or 4) from matrix_size, is stored as W[0][0], next state LOAD_W.
REQ-018 matrix_size is ignored on every beat except the first of a load.
REQ-019 LOAD_W stores elements row-major into W until N*N accepted, then LOAD_X; LOAD_X stores N*N elements into X, then FEED.
REQ-020 in_ready is low in FEED; in_valid in FEED is ignored, nothing stored.
REQ-021 FEED lasts exactly 2N-1 cycles, step t = 0..2N-2; feed_valid is high on the cycle after the final X element is accepted.
REQ-022 At step t: west lane i = W[i][t-i] if 0 <= t-i < N, else 0; north lane j = X[t-j][j] if 0 <= t-j < N, else 0.
REQ-023 Lanes with index >= N are 0 throughout FEED.
REQ-024 feed_first high only at t = 0; feed_last high only at t = 2N-2; both high on no other cycle.
REQ-025 After t = 2N-2 next state is IDLE; in_ready is high the cycle after feed_last, enabling back-to-back products.
REQ-026 All outputs are registered; outside FEED, feed_valid/first/last = 0 and west_data/north_data = 0.
REQ-027 Element values pass unmodified; no arithmetic on data.

Reset
REQ-028 rst_n low asynchronously forces IDLE, clears counters, W, X, latched size; in_ready = 1 after reset release, all other outputs 0.
REQ-029 Reset mid-load or mid-feed abandons the product; no wavefront of it appears after release.

Structure
REQ-030 Shared package ss_pkg holds the state enum, DATA_W, MAX_N and the 2x2/4x4 size encoding, shared with the systolic array.
REQ-031 One sub-module ss_mat_buf (MAX_N x MAX_N register file, row-major write index, combinational element read) instantiated twice, for W and X.
REQ-032 Counters: element index (0..MAX_N*MAX_N-1) and step t (0..2*MAX_N-2), sized from MAX_N.

Verification
REQ-033 Size 2, W = 1,2,3,4, X = 5,6,7,8 contiguous -> t0 west {0,1} north {0,5}; t1 west {3,2} north {6,7}; t2 west {4,0} north {8,0} with feed_last (lists {lane1,lane0}).
REQ-034 Size 4, W = 1..16, X = identity -> 7 feed cycles; t0 west lane0 = 1, north lane0 = 1; t6 west lane3 = 16, north lane3 = 1, other lanes 0, feed_last.
REQ-035 Size 2 load with in_valid toggling 1,0,1,0 and matrix_size flipped after first beat -> same wavefronts as REQ-033, feed_size = 0.
REQ-036 rst_n pulsed low after 10 of 32 size-4 elements -> no feed_valid; new size-2 load then produces REQ-033 output exactly.
REQ-037 in_valid held high with values 0xFFFF during FEED -> ignored; next product loaded right after feed_last feeds correctly.
